key_sequencer: RTL and testbench

KEY_SEQUENCER -- requirements
Module: key_sequencer

---
 rtl/game_pkg.sv | 30 +++
 rtl/pulse_timer.sv | 30 +++
 rtl/key_sequencer.sv | 154 +++++++++++++++
 tb/tb_key_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default timing constants for the key sequencer.
package game_pkg;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      KEY   = 3'd1,
      KGAP  = 3'd2,
      ENTER = 3'd3,
      EGAP  = 3'd4,
      DONE  = 3'd5
   } seq_state_t;

   // One code symbol selects one of the four keys I1..I4
   typedef logic [1:0] sym_t;

   localparam int DEF_PULSE_W = 2;
   localparam int DEF_GAP_W   = 2;
   localparam int DEF_MAX_SYM = 7;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Symbol s drives key bit s
   function automatic logic [3:0] sym_onehot(input sym_t s);
      return 4'b0001 << s;
   endfunction

endpackage

// File: rtl/pulse_timer.sv
// Down-counter that times one pulse or gap: load a length, count down,
// and flag expiry on the last cycle of the interval.
import game_pkg::*;

module pulse_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] len,
   output logic         expire
);

   logic [W-1:0] cnt;

   // Loading len-1 makes the interval exactly len cycles including the expiry cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= len - W'(1);
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/key_sequencer.sv
// Buffers up to MAX_SYM key symbols and replays them as timed one-hot key
// pulses followed by an enter pulse.
// Optional feature: define SEQ_REPLAY_EN to keep the buffer after DONE so a
// further start replays the same code; otherwise the count clears in DONE.
import game_pkg::*;

module key_sequencer #(
   parameter int PULSE_W = DEF_PULSE_W,
   parameter int GAP_W   = DEF_GAP_W,
   parameter int MAX_SYM = DEF_MAX_SYM
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [1:0] load_sym,
   output logic       load_ready,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [3:0] key_out,
   output logic       enter_out,
   output logic [2:0] sym_count
);

   localparam int TMR_W = $clog2(max_int(PULSE_W, GAP_W) + 1);

   seq_state_t       state;
   logic [2:0]       idx;
   logic [2:0]       nxt_idx;
   logic             more_keys;
   sym_t             sym_buf [MAX_SYM];
   logic             start_acc;
   logic             load_acc;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_len;
   logic             expire;

   // Start in IDLE always wins over a simultaneous load
   assign start_acc  = start && (state == IDLE);
   assign load_ready = !busy && (int'(sym_count) < MAX_SYM);
   assign load_acc   = load && load_ready && !start_acc;
   assign nxt_idx    = idx + 3'd1;
   assign more_keys  = ({1'b0, nxt_idx} < {1'b0, sym_count});

   pulse_timer #(.W(TMR_W)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (tmr_load),
      .len    (tmr_len),
      .expire (expire)
   );

   // Reload the timer on every transition into a pulse or gap state
   always_comb begin
      tmr_load = 1'b0;
      tmr_len  = TMR_W'(PULSE_W);
      case (state)
         IDLE:  tmr_load = start;
         KEY: begin
            tmr_load = expire;
            tmr_len  = TMR_W'(GAP_W);
         end
         KGAP:  tmr_load = expire;
         ENTER: begin
            tmr_load = expire;
            tmr_len  = TMR_W'(GAP_W);
         end
         default: tmr_load = 1'b0;
      endcase
   end

   // Symbol storage, written at the current count on an accepted load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MAX_SYM; i++) begin
            sym_buf[i] <= '0;
         end
      end else if (load_acc) begin
         sym_buf[sym_count] <= load_sym;
      end
   end

   // Sequencer FSM with registered key/enter/busy/done outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         sym_count <= '0;
         key_out   <= '0;
         enter_out <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load_acc) begin
            sym_count <= sym_count + 3'd1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  idx  <= '0;
                  if (sym_count != '0) begin
                     state   <= KEY;
                     key_out <= sym_onehot(sym_buf[0]);
                  end else begin
                     state     <= ENTER;
                     enter_out <= 1'b1;
                  end
               end
            end
            KEY: begin
               if (expire) begin
                  key_out <= '0;
                  state   <= KGAP;
               end
            end
            KGAP: begin
               if (expire) begin
                  if (more_keys) begin
                     idx     <= nxt_idx;
                     key_out <= sym_onehot(sym_buf[nxt_idx]);
                     state   <= KEY;
                  end else begin
                     enter_out <= 1'b1;
                     state     <= ENTER;
                  end
               end
            end
            ENTER: begin
               if (expire) begin
                  enter_out <= 1'b0;
                  state     <= EGAP;
               end
            end
            EGAP: begin
               if (expire) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
`ifndef SEQ_REPLAY_EN
               sym_count <= '0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_sequencer.sv
// Directed bench for key_sequencer with default PULSE_W/GAP_W/MAX_SYM.
// Expectations follow the SEQ_REPLAY_EN setting of the build.
module tb_key_sequencer;

   logic       clk;
   logic       reset;
   logic       load;
   logic [1:0] load_sym;
   logic       load_ready;
   logic       start;
   logic       busy;
   logic       done;
   logic [3:0] key_out;
   logic       enter_out;
   logic [2:0] sym_count;

   int n_chk;
   int n_bad;
   logic [1:0] exp_sym [8];

   key_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_sym   (load_sym),
      .load_ready (load_ready),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .key_out    (key_out),
      .enter_out  (enter_out),
      .sym_count  (sym_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_one(input logic [1:0] s);
      load     = 1'b1;
      load_sym = s;
      tick;
      load = 1'b0;
   endtask

   task automatic apply_reset;
      #2 reset = 1'b1;
      #3 reset = 1'b0;
      tick;
   endtask

   // Start a sequence of n buffered symbols and check every cycle until idle.
   // With disturb set, a load rides on the start and another start+load is
   // issued mid-sequence; both must be ignored.
   task automatic run_seq(input int n, input bit disturb);
      int total;
      int slot;
      logic [3:0] ek;
      logic       ee;
      total    = (n + 1) * 4;
      start    = 1'b1;
      load     = disturb;
      load_sym = 2'd0;
      for (int c = 1; c <= total + 2; c++) begin
         tick;
         start = 1'b0;
         load  = 1'b0;
         if (disturb && c == 3) begin
            start    = 1'b1;
            load     = 1'b1;
            load_sym = 2'd2;
         end
         ek = 4'b0000;
         ee = 1'b0;
         if (c <= total) begin
            slot = (c - 1) / 4;
            if (((c - 1) % 4) < 2) begin
               if (slot < n) ek = 4'b0001 << exp_sym[slot];
               else          ee = 1'b1;
            end
         end
         chk($sformatf("key_c%0d", c), 32'(key_out), 32'(ek));
         chk($sformatf("enter_c%0d", c), 32'(enter_out), 32'(ee));
         chk($sformatf("done_c%0d", c), 32'(done), 32'(c == total + 1));
         if (c <= total) chk($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
         if (c == total) chk("count_in_seq", 32'(sym_count), 32'(n));
         if (c == total + 2) chk("busy_after", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      n_chk    = 0;
      n_bad    = 0;
      reset    = 1'b1;
      load     = 1'b0;
      load_sym = 2'd0;
      start    = 1'b0;
      #12;
      chk("rst_key", 32'(key_out), 32'd0);
      chk("rst_enter", 32'(enter_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_count", 32'(sym_count), 32'd0);
      chk("rst_ready", 32'(load_ready), 32'd1);
      reset = 1'b0;
      tick;

      // Four distinct keys, done at cycle 21
      for (int i = 0; i < 4; i++) begin
         exp_sym[i] = 2'(i);
         load_one(2'(i));
      end
      chk("count4", 32'(sym_count), 32'd4);
      chk("ready4", 32'(load_ready), 32'd1);
      run_seq(4, 1'b0);

      // Second start after done
`ifdef SEQ_REPLAY_EN
      chk("count_kept", 32'(sym_count), 32'd4);
      run_seq(4, 1'b0);
`else
      chk("count_clr", 32'(sym_count), 32'd0);
      run_seq(0, 1'b0);
`endif

      // Reset in the middle of the third key pulse
      apply_reset;
      for (int i = 0; i < 4; i++) load_one(2'(i));
      start = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick;
         start = 1'b0;
      end
      chk("third_key", 32'(key_out), 32'b0100);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_key", 32'(key_out), 32'd0);
      chk("mid_rst_count", 32'(sym_count), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(load_ready), 32'd1);
      #2 reset = 1'b0;
      tick;

      // Empty buffer: enter only, done 5 cycles after start
      run_seq(0, 1'b0);

      // Buffer full after 7 loads, 8th ignored
      apply_reset;
      for (int i = 0; i < 7; i++) begin
         exp_sym[i] = 2'd2;
         load_one(2'd2);
      end
      chk("full_count", 32'(sym_count), 32'd7);
      chk("full_ready", 32'(load_ready), 32'd0);
      load_one(2'd1);
      chk("full_count8", 32'(sym_count), 32'd7);
      run_seq(7, 1'b0);

      // Start with load, and start+load while busy
      apply_reset;
      exp_sym[0] = 2'd1;
      exp_sym[1] = 2'd3;
      load_one(2'd1);
      load_one(2'd3);
      chk("dist_count", 32'(sym_count), 32'd2);
      run_seq(2, 1'b1);
`ifdef SEQ_REPLAY_EN
      chk("dist_count_end", 32'(sym_count), 32'd2);
`else
      chk("dist_count_end", 32'(sym_count), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
